// File: rtl/ctrl_pipeline_if.sv
// Bundle of ID-stage controls in and per-stage controls/hazard selects out for ctrl_pipeline.
// master drives the decoded ID fields; slave is the pipeline control unit.
interface ctrl_pipeline_if;
  logic       RegDst;
  logic       Branch;
  logic       Jump;
  logic       MemRead;
  logic       MemtoReg;
  logic       MemWrite;
  logic       ALUSrc;
  logic       RegWrite;
  logic       IF_flush;
  logic [1:0] ALUOp;
  logic [4:0] rs_id;
  logic [4:0] rt_id;
  logic [4:0] rd_id;

  logic       ex_RegDst;
  logic       ex_ALUSrc;
  logic [1:0] ex_ALUOp;
  logic       mem_MemRead;
  logic       mem_MemWrite;
  logic       wb_MemtoReg;
  logic       wb_RegWrite;
  logic [4:0] wb_dst;
  logic       PCWrite;
  logic       IFID_write;
  logic       IFID_flush;
  logic       stall;
  logic [1:0] ForwardA;
  logic [1:0] ForwardB;

  modport master (
    output RegDst, Branch, Jump, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite,
           IF_flush, ALUOp, rs_id, rt_id, rd_id,
    input  ex_RegDst, ex_ALUSrc, ex_ALUOp, mem_MemRead, mem_MemWrite,
           wb_MemtoReg, wb_RegWrite, wb_dst, PCWrite, IFID_write, IFID_flush,
           stall, ForwardA, ForwardB
  );

  modport slave (
    input  RegDst, Branch, Jump, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite,
           IF_flush, ALUOp, rs_id, rt_id, rd_id,
    output ex_RegDst, ex_ALUSrc, ex_ALUOp, mem_MemRead, mem_MemWrite,
           wb_MemtoReg, wb_RegWrite, wb_dst, PCWrite, IFID_write, IFID_flush,
           stall, ForwardA, ForwardB
  );
endinterface

// File: rtl/ctrl_pipeline.sv
// Pipeline control banks (ID/EX, EX/MEM, MEM/WB) with hazard detection and forwarding selects.
// Macro FORWARD_EN: defined = forwarding + load-use stall only; undefined = no forwarding, stall on any RAW.
module ctrl_pipeline (
  input  logic           clk,
  input  logic           reset,
  ctrl_pipeline_if.slave bus
);

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } idex_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [4:0] dst;
  } exmem_t;

  typedef struct packed {
    logic       mem_to_reg;
    logic       reg_write;
    logic [4:0] dst;
  } memwb_t;

  idex_t  idex_d,  idex_q;
  exmem_t exmem_d, exmem_q;
  memwb_t memwb_d, memwb_q;

  logic [4:0] ex_dst_s;
  logic       load_use_s;
  logic       stall_s;
  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;
  logic       unused_ctrl_s;

  // A writer to register 0 never creates a dependency.
  function automatic logic raw_hit(input logic       wr,
                                   input logic [4:0] dst,
                                   input logic [4:0] rs,
                                   input logic [4:0] rt);
    return wr && (dst != 5'd0) && ((dst == rs) || (dst == rt));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic       mem_wr,
                                         input logic [4:0] mem_dst,
                                         input logic       wb_wr,
                                         input logic [4:0] wb_dst,
                                         input logic [4:0] src);
    logic [1:0] sel;
    if (mem_wr && (mem_dst != 5'd0) && (mem_dst == src)) begin
      sel = 2'b10;
    end else if (wb_wr && (wb_dst != 5'd0) && (wb_dst == src)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Branch and Jump resolve in ID and are deliberately not carried into the banks.
  always_comb begin
    unused_ctrl_s = bus.Branch ^ bus.Jump;
  end

  // Hazard detection and operand forwarding from current bank state and ID fields.
  always_comb begin
    ex_dst_s   = idex_q.reg_dst ? idex_q.rd : idex_q.rt;
    load_use_s = idex_q.mem_read && (ex_dst_s != 5'd0) &&
                 ((ex_dst_s == bus.rs_id) || (ex_dst_s == bus.rt_id));
`ifdef FORWARD_EN
    stall_s = load_use_s;
    fwd_a_s = fwd_sel(exmem_q.reg_write, exmem_q.dst, memwb_q.reg_write, memwb_q.dst, idex_q.rs);
    fwd_b_s = fwd_sel(exmem_q.reg_write, exmem_q.dst, memwb_q.reg_write, memwb_q.dst, idex_q.rt);
`else
    // WB is not checked: the register file is assumed to write before it is read.
    stall_s = load_use_s ||
              raw_hit(idex_q.reg_write, ex_dst_s, bus.rs_id, bus.rt_id) ||
              raw_hit(exmem_q.reg_write, exmem_q.dst, bus.rs_id, bus.rt_id);
    fwd_a_s = 2'b00;
    fwd_b_s = 2'b00;
`endif
  end

  // Next ID/EX contents: a zero bubble on stall, otherwise the decoded ID fields.
  always_comb begin
    idex_d = '0;
    if (stall_s) begin
      idex_d = '0;
    end else begin
      idex_d.reg_dst    = bus.RegDst;
      idex_d.alu_src    = bus.ALUSrc;
      idex_d.alu_op     = bus.ALUOp;
      idex_d.mem_read   = bus.MemRead;
      idex_d.mem_write  = bus.MemWrite;
      idex_d.mem_to_reg = bus.MemtoReg;
      idex_d.reg_write  = bus.RegWrite;
      idex_d.rs         = bus.rs_id;
      idex_d.rt         = bus.rt_id;
      idex_d.rd         = bus.rd_id;
    end
  end

  // EX/MEM and MEM/WB advance every cycle, independent of stall.
  always_comb begin
    exmem_d.mem_read   = idex_q.mem_read;
    exmem_d.mem_write  = idex_q.mem_write;
    exmem_d.mem_to_reg = idex_q.mem_to_reg;
    exmem_d.reg_write  = idex_q.reg_write;
    exmem_d.dst        = ex_dst_s;
    memwb_d.mem_to_reg = exmem_q.mem_to_reg;
    memwb_d.reg_write  = exmem_q.reg_write;
    memwb_d.dst        = exmem_q.dst;
  end

  // Bank registers; reset clears everything asynchronously, including a pending bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  // Stage outputs come straight from the banks; fetch controls from the stall decision.
  always_comb begin
    bus.ex_RegDst    = idex_q.reg_dst;
    bus.ex_ALUSrc    = idex_q.alu_src;
    bus.ex_ALUOp     = idex_q.alu_op;
    bus.mem_MemRead  = exmem_q.mem_read;
    bus.mem_MemWrite = exmem_q.mem_write;
    bus.wb_MemtoReg  = memwb_q.mem_to_reg;
    bus.wb_RegWrite  = memwb_q.reg_write;
    bus.wb_dst       = memwb_q.dst;
    bus.stall        = stall_s;
    bus.PCWrite      = ~stall_s;
    bus.IFID_write   = ~stall_s;
    bus.IFID_flush   = bus.IF_flush & ~stall_s;
    bus.ForwardA     = fwd_a_s;
    bus.ForwardB     = fwd_b_s;
  end

endmodule

// File: doc/ctrl_pipeline.md
CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

Interface
REQ-001 SHALL have port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-high; clears all pipeline state.
REQ-003 SHALL have inputs RegDst, Branch, Jump, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, IF_flush, each 1 bit: decoded ID-stage controls from the opcode decoder.
REQ-004 SHALL have input ALUOp, 2 bits: ID-stage ALU operation class.
REQ-005 SHALL have inputs rs_id, rt_id, rd_id, each 5 bits: ID-stage register fields.
REQ-006 SHALL have outputs ex_RegDst, ex_ALUSrc (1 bit) and ex_ALUOp (2 bits): EX-stage controls.
REQ-007 SHALL have outputs mem_MemRead, mem_MemWrite, 1 bit: MEM-stage controls.
REQ-008 SHALL have outputs wb_MemtoReg, wb_RegWrite (1 bit) and wb_dst (5 bits): WB-stage controls and destination register.
REQ-009 SHALL have outputs PCWrite, IFID_write, IFID_flush, stall, 1 bit each: fetch-side hazard controls.
REQ-010 SHALL have outputs ForwardA, ForwardB, 2 bits each: EX operand source selects (00 register file, 10 MEM, 01 WB).

Function
REQ-011 SHALL hold three control banks: ID/EX, EX/MEM and MEM/WB. ID controls appear at ex_* 1 cycle later, at mem_* after 2 cycles, and at wb_* after 3 cycles.
REQ-012 The ID/EX bank SHALL capture ALU/memory/WB controls plus rs_id, rt_id and rd_id. Branch and Jump SHALL NOT propagate, because they resolve in ID.
REQ-013 ex_dst SHALL equal ex_rd when ex_RegDst is 1, else ex_rt. This value SHALL be carried to mem_dst, then to wb_dst.
REQ-014 The load-use hazard SHALL be: ex_MemRead=1 and ex_dst!=0 and (ex_dst==rs_id or ex_dst==rt_id).
REQ-015 On hazard, the unit SHALL:
- assert stall=1, PCWrite=0 and IFID_write=0;
- load a bubble into ID/EX on the next edge (all controls 0, ALUOp=00, register fields 0).
REQ-016 Without hazard, the unit SHALL drive stall=0, PCWrite=1 and IFID_write=1.
REQ-017 IFID_flush SHALL equal IF_flush AND NOT stall. When stall and flush coincide, stall wins and the flush is re-evaluated next cycle.
REQ-018 EX/MEM and MEM/WB SHALL advance every cycle regardless of stall.
REQ-019 ForwardA SHALL be:
- 10 if mem_RegWrite and mem_dst!=0 and mem_dst==ex_rs;
- else 01 if wb_RegWrite and wb_dst!=0 and wb_dst==ex_rs;
- else 00.
REQ-020 ForwardB SHALL follow REQ-019 using ex_rt. MEM priority over WB is mandatory.
REQ-021 Register 0 SHALL never cause a hazard or a forward.
REQ-022 Stall, forwarding and flush outputs SHALL be combinational from current state and inputs; only the banks are registered.
REQ-023 Input ALUOp=XX from non-ALU opcodes SHALL be registered unmodified. Bubbles SHALL always be 00.

Reset
REQ-024 While reset=1, all bank contents SHALL be 0 immediately (asynchronously).
REQ-025 During reset, all ex_*/mem_*/wb_* outputs SHALL be 0.
REQ-026 During reset, ForwardA/B SHALL be 00, and stall SHALL follow REQ-014 (0 because ex_MemRead=0), giving PCWrite=1 and IFID_write=1.
REQ-027 Reset asserted mid-stall SHALL discard the pending bubble. The first edge after release SHALL load the ID inputs normally.

Configuration
REQ-028 Macro FORWARD_EN SHALL select forwarding behaviour.
REQ-029 With FORWARD_EN defined: REQ-014 through REQ-020 apply as written.
REQ-030 Without FORWARD_EN:
- ForwardA/B SHALL be tied to 00;
- the stall condition SHALL widen to any RAW hazard: (ex_RegWrite and ex_dst!=0 and ex_dst in {rs_id, rt_id}) or (mem_RegWrite and mem_dst!=0 and mem_dst in {rs_id, rt_id});
- stall consequences SHALL be identical to REQ-015.

Verification
REQ-031 Scenario: lw $8 then add using rs=8 on the next cycle -> one cycle with stall=1, PCWrite=0, then ex_* all 0 (bubble) and ForwardA=01 when add reaches EX.
REQ-032 Scenario: add $9 (RegDst=1, rd=9) then sub with rt=9 (FORWARD_EN) -> no stall, ForwardB=10 in sub's EX cycle.
REQ-033 Scenario: writer to $0 followed by reader of rs=0 -> stall=0, ForwardA=00 in all cycles.
REQ-034 Scenario: IF_flush=1 in the same cycle as a load-use hazard -> IFID_flush=0, stall=1; next cycle IF_flush=1 gives IFID_flush=1.
REQ-035 Scenario: sw (MemWrite=1, ALUSrc=1, ALUOp=00) -> mem_MemWrite=1 exactly 2 cycles later; wb_RegWrite stays 0.
REQ-036 Scenario: reset pulsed mid-stall -> all outputs 0 or 00 immediately, PCWrite=1; without FORWARD_EN, add $9 then reader of $9 -> stall=2 cycles.
